dmem_port_arbiter: RTL
======================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADDR_W, 10, data-memory word address width
- DATA_W, 32, data word width
- STARVE_LIMIT, 8, maximum lost network arbitration cycles before forced network grant
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- core_state_i  in  state_e  core state (IDLE/RUN/ERR)
- core_req_v_i  in  1  core memory access request
- core_we_i  in  1  core write enable
- core_addr_i  in  ADDR_W  core address
- core_wdata_i  in  DATA_W  core write data
- core_stall_o  out  1  core request not granted this cycle
- core_rdata_v_o  out  1  core read data valid
- core_rdata_o  out  DATA_W  core read data
- net_req_v_i  in  1  network memory request valid
- net_we_i  in  1  network write enable
- net_addr_i  in  ADDR_W  network address
- net_wdata_i  in  DATA_W  network write data
- net_req_ready_o  out  1  network request accepted when high with valid
- net_resp_v_o  out  1  network read response valid
- net_resp_data_o  out  DATA_W  network read response data
- net_resp_yumi_i  in  1  network consumes response
- mem_en_o, mem_we_o  out  1 each  memory port enable and write
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid one cycle after a read enable
REQ-003 clk SHALL be the only clock; reset SHALL be synchronous and active-high.

Function
REQ-004 core_cand = core_req_v_i && core_state_i==RUN; net_cand = net_req_v_i && arbiter FSM in ARB_READY.
REQ-005 Grant rule: core_state_i!=RUN -> network wins; RUN -> core wins, except when the forced-grant condition of REQ-019 holds.
REQ-006 At most one grant per cycle; the granted requester's we/addr/wdata SHALL drive the mem_* outputs combinationally, with mem_en_o=1; no grant -> mem_en_o=0, mem_we_o=0.
REQ-007 core_stall_o = core_cand && !core_grant (combinational).
REQ-008 net_req_ready_o = net_grant; a network transfer occurs only when net_req_v_i && net_req_ready_o.
REQ-009 Core read granted in cycle N -> core_rdata_v_o=1 and core_rdata_o=mem_rdata_i in cycle N+1; core writes produce no response.
REQ-010 Network writes produce no response; the FSM stays in ARB_READY.
REQ-011 FSM states: ARB_READY, ARB_NET_RD, ARB_NET_HOLD.
REQ-012 Transitions:
- ARB_READY -> ARB_NET_RD on a network read grant
- ARB_NET_RD -> ARB_NET_HOLD unconditionally, capturing mem_rdata_i into the response register
- ARB_NET_HOLD -> ARB_READY on net_resp_yumi_i
REQ-013 net_resp_v_o=1 only in ARB_NET_HOLD; net_resp_data_o SHALL hold stable until yumi.
REQ-014 Yumi arriving in ARB_NET_HOLD: net_req_ready_o stays 0 that cycle; a new network request is accepted no earlier than the next cycle.
REQ-015 The core keeps full memory access while the FSM is in ARB_NET_RD or ARB_NET_HOLD; one network read is outstanding at most.
REQ-016 core_state_i changing mid-transaction SHALL NOT abort a pending network response.

Reset
REQ-017 On reset:
- FSM -> ARB_READY; core_rdata_v_o=0, net_resp_v_o=0, net_resp_data_o=0, starvation counter=0
- any pending network response is discarded
REQ-018 During reset, mem_en_o=0, net_req_ready_o=0 and core_stall_o=0.

Configuration
REQ-019 With NET_STARVE_LIMIT_EN defined:
- a counter increments, saturating at STARVE_LIMIT, each cycle net_cand is true and not granted; it clears on net grant or !net_cand
- when counter==STARVE_LIMIT and net_cand, the network wins and the core stalls that cycle
REQ-020 Without NET_STARVE_LIMIT_EN, no counter exists and the network is granted in RUN only when core_cand=0.

Verification
REQ-021 core_state_i=IDLE, net write addr 0x010 data 0xDEADBEEF -> net_req_ready_o=1, mem_we_o=1, mem_addr_o=0x010 in the same cycle.
REQ-022 Net read addr 0x010 -> net_resp_v_o=1 two cycles later with data 0xDEADBEEF; response held while yumi=0 for 5 cycles; net_req_ready_o=0 throughout.
REQ-023 RUN, core and net request together -> core granted, core_stall_o=0, net_req_ready_o=0; core read returns core_rdata_v_o=1 next cycle.
REQ-024 NET_STARVE_LIMIT_EN, RUN, core_req_v_i held 1, net_req_v_i held 1 -> net granted on cycle 9 with core_stall_o=1 that cycle; macro off -> net never granted.
REQ-025 Reset asserted in ARB_NET_HOLD -> net_resp_v_o=0 the cycle after, and the FSM accepts a new net request immediately after reset deasserts.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the core and the
// network. The core wins while running; the network gets the port when the
// core is not running or not requesting. One network read may be outstanding;
// its response is held in a register until the network consumes it (yumi).
// Optional feature macro: NET_STARVE_LIMIT_EN forces a network grant after
// STARVE_LIMIT consecutive lost arbitration cycles.

package dmem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;
endpackage

module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  state_e            core_state_i,
  input  logic              core_req_v_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_stall_o,
  output logic              core_rdata_v_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              net_req_v_i,
  input  logic              net_we_i,
  input  logic [ADDR_W-1:0] net_addr_i,
  input  logic [DATA_W-1:0] net_wdata_i,
  output logic              net_req_ready_o,
  output logic              net_resp_v_o,
  output logic [DATA_W-1:0] net_resp_data_o,
  input  logic              net_resp_yumi_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ARB_READY    = 2'd0,
    ARB_NET_RD   = 2'd1,
    ARB_NET_HOLD = 2'd2
  } arb_e;

  arb_e              arb_q, arb_d;
  logic              core_rd_q, core_rd_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic core_cand, net_cand;
  logic core_grant, net_grant;
  logic force_net;

  // Candidates are masked by reset so nothing is granted or stalled in reset.
  assign core_cand = !reset && core_req_v_i && (core_state_i == RUN);
  assign net_cand  = !reset && net_req_v_i && (arb_q == ARB_READY);

`ifdef NET_STARVE_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_net = net_cand && (starve_q == LIMIT);

  // Count consecutive lost network cycles, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!net_cand || net_grant) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_net = 1'b0;
`endif

  // Grant decision: core first unless it is idle or the network is forced.
  always_comb begin
    core_grant = 1'b0;
    net_grant  = 1'b0;
    if (force_net || !core_cand) begin
      net_grant = net_cand;
    end else begin
      core_grant = 1'b1;
    end
  end

  // Steer the granted requester onto the memory port.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (core_grant) begin
      mem_en_o    = 1'b1;
      mem_we_o    = core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end else if (net_grant) begin
      mem_en_o    = 1'b1;
      mem_we_o    = net_we_i;
      mem_addr_o  = net_addr_i;
      mem_wdata_o = net_wdata_i;
    end
  end

  assign core_stall_o    = core_cand && !core_grant;
  assign net_req_ready_o = net_grant;

  // Network read FSM next state and response capture; core read tracking.
  always_comb begin
    arb_d       = arb_q;
    resp_data_d = resp_data_q;
    core_rd_d   = core_grant && !core_we_i;
    case (arb_q)
      ARB_READY: begin
        if (net_grant && !net_we_i) begin
          arb_d = ARB_NET_RD;
        end
      end
      ARB_NET_RD: begin
        arb_d       = ARB_NET_HOLD;
        resp_data_d = mem_rdata_i;
      end
      ARB_NET_HOLD: begin
        if (net_resp_yumi_i) begin
          arb_d = ARB_READY;
        end
      end
      default: arb_d = ARB_READY;
    endcase
  end

  // State, response and core read-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_q       <= ARB_READY;
      resp_data_q <= '0;
      core_rd_q   <= 1'b0;
    end else begin
      arb_q       <= arb_d;
      resp_data_q <= resp_data_d;
      core_rd_q   <= core_rd_d;
    end
  end

  assign net_resp_v_o    = (arb_q == ARB_NET_HOLD);
  assign net_resp_data_o = resp_data_q;
  assign core_rdata_v_o  = core_rd_q;
  assign core_rdata_o    = mem_rdata_i;

endmodule
